button_event_detector: RTL and testbench

Classifies a clean, debounced push-button level into one-cycle event pulses: press, release, short press, long press and double click. Sits directly downstream of the debouncer and consumes its `debounced` output on the same clock. Downstream control logic uses these pulses, so it never needs its own button timers.

---
 rtl/button_event_detector.sv | 114 +++++++++++
 tb/tb_button_event_detector.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_detector.sv
// Turns a debounced button level into one-cycle press/release/short/long/double-click pulses.
// One counter serves both the hold timer and the release-to-second-press gap timer.
module button_event_detector #(
   parameter int LONG_CYCLES = 100_000_000,
   parameter int GAP_CYCLES  = 30_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       debounced,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       short_press,
   output logic       long_press,
   output logic       double_click,
   output logic       held,
   output logic [2:0] state_o
);

   localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE           = 3'd0,
      S_PRESSED        = 3'd1,
      S_LONG_HELD      = 3'd2,
      S_WAIT_SECOND    = 3'd3,
      S_SECOND_PRESSED = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q;
   logic             press_q, release_q, short_q, long_q, dbl_q;
   logic             short_d, long_d, dbl_d;
   logic             rise, fall;

   assign rise = debounced & ~db_q;
   assign fall = ~debounced & db_q;

   // State register plus the shared timer, which restarts on every state change.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:           if (rise) state_d = S_PRESSED;
         S_PRESSED: begin
            if (fall)                     state_d = S_WAIT_SECOND;
            else if (cnt_q == LONG_LAST)  state_d = S_LONG_HELD;
         end
         S_LONG_HELD:      if (fall) state_d = S_IDLE;
         S_WAIT_SECOND: begin
            if (rise)                     state_d = S_SECOND_PRESSED;
            else if (cnt_q == GAP_LAST)   state_d = S_IDLE;
         end
         S_SECOND_PRESSED: if (fall) state_d = S_IDLE;
         default:          state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == S_PRESSED || state_q == S_WAIT_SECOND) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Event decode; the edge that wins the priority race suppresses the timer event.
   always_comb begin
      long_d  = (state_q == S_PRESSED)        && !fall && (cnt_q == LONG_LAST);
      short_d = (state_q == S_WAIT_SECOND)    && !rise && (cnt_q == GAP_LAST);
      dbl_d   = (state_q == S_SECOND_PRESSED) && fall;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_q      <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         dbl_q     <= 1'b0;
      end else begin
         db_q      <= debounced;
         press_q   <= rise;
         release_q <= fall;
         short_q   <= short_d;
         long_q    <= long_d;
         dbl_q     <= dbl_d;
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign short_press   = short_q;
   assign long_press    = long_q;
   assign double_click  = dbl_q;
   assign held          = db_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_button_event_detector.sv
// Bench for button_event_detector: directed gestures and random streams against a
// timestamp-based gesture model; outputs packed {press, release, short, long, dbl, held}.
module tb_button_event_detector;

   localparam int LONG = 10;
   localparam int GAP  = 6;

   logic       clk;
   logic       reset;
   logic       debounced;
   logic       press_pulse, release_pulse, short_press, long_press, double_click, held;
   logic [2:0] state_o;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [5:0] exp_q[$];
   logic [5:0] obs_q[$];

   // Gesture model: edge index of the first press and first release of the gesture.
   int   t;
   logic m_level;
   logic g_active;
   int   rise_t;
   int   fall_t;
   logic is_long;
   logic is_second;

   button_event_detector #(
      .LONG_CYCLES(LONG),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .debounced    (debounced),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .short_press  (short_press),
      .long_press   (long_press),
      .double_click (double_click),
      .held         (held),
      .state_o      (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      t         = 0;
      m_level   = 1'b0;
      g_active  = 1'b0;
      rise_t    = 0;
      fall_t    = -1;
      is_long   = 1'b0;
      is_second = 1'b0;
   endtask

   // Drive one sample, advance one edge, record expected and observed outputs.
   task automatic cycle(input logic d);
      logic [5:0] e;
      logic       r, f;
      debounced = d;
      @(posedge clk);
      e = '0;
      if (!reset) begin
         model_clear();
      end else begin
         t++;
         r    = d & ~m_level;
         f    = ~d & m_level;
         e[5] = r;
         e[4] = f;
         e[0] = d;
         if (!g_active) begin
            if (r) begin
               g_active  = 1'b1;
               rise_t    = t;
               fall_t    = -1;
               is_long   = 1'b0;
               is_second = 1'b0;
            end
         end else if (is_second) begin
            if (f) begin
               e[1]     = 1'b1;
               g_active = 1'b0;
            end
         end else if (is_long) begin
            if (f) g_active = 1'b0;
         end else if (fall_t < 0) begin
            if (f) fall_t = t;
            else if (t - rise_t == LONG) begin
               e[2]    = 1'b1;
               is_long = 1'b1;
            end
         end else begin
            if (r) is_second = 1'b1;
            else if (t - fall_t == GAP) begin
               e[3]     = 1'b1;
               g_active = 1'b0;
            end
         end
         m_level = d;
      end
      #1;
      exp_q.push_back(e);
      obs_q.push_back({press_pulse, release_pulse, short_press, long_press, double_click, held});
   endtask

   task automatic run(input logic d, input int n);
      for (int i = 0; i < n; i++) cycle(d);
   endtask

   task automatic test_reset();
      logic [5:0] e, o;
      reset = 1'b0;
      debounced = 1'b0;
      model_clear();
      for (int i = 0; i < 6; i++) cycle(logic'(i % 2));
      reset = 1'b1;
      cycle(1'b1);
      run(1'b1, 1);
      run(1'b0, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_seq: got %b expected %b", o, e);
         end
      end
   endtask

   task automatic test_short_press();
      logic [5:0] e, o;
      int ns, nl, nd, idx, short_idx;
      ns = 0; nl = 0; nd = 0; idx = 0; short_idx = -1;
      run(1'b0, 2);
      run(1'b1, 3);
      run(1'b0, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (o[3] && short_idx < 0) short_idx = idx;
         ns += int'(o[3]); nl += int'(o[2]); nd += int'(o[1]);
         idx++;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL short_seq: got %b expected %b", o, e);
         end
      end
      n_cmp++;
      if (ns !== 1 || nl !== 0 || nd !== 0) begin
         n_fail++;
         $display("FAIL short_counts: got short=%0d long=%0d dbl=%0d expected 1/0/0", ns, nl, nd);
      end
      // F0 is sample index 5, so the short pulse follows edge F0+6.
      n_cmp++;
      if (short_idx !== 11) begin
         n_fail++;
         $display("FAIL short_position: got %0d expected 11", short_idx);
      end
   endtask

   task automatic test_long_press();
      logic [5:0] e, o;
      int ns, nl, nd, ns2, nl2;
      ns = 0; nl = 0; nd = 0; ns2 = 0; nl2 = 0;
      run(1'b1, 15);
      run(1'b0, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         ns += int'(o[3]); nl += int'(o[2]); nd += int'(o[1]);
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL long_seq: got %b expected %b", o, e);
         end
      end
      n_cmp++;
      if (ns !== 0 || nl !== 1 || nd !== 0) begin
         n_fail++;
         $display("FAIL long_counts: got short=%0d long=%0d dbl=%0d expected 0/1/0", ns, nl, nd);
      end
      // Fall sampled exactly at E0+10 beats the long expiry.
      run(1'b1, 10);
      run(1'b0, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         ns2 += int'(o[3]); nl2 += int'(o[2]);
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL long_edge_seq: got %b expected %b", o, e);
         end
      end
      n_cmp++;
      if (ns2 !== 1 || nl2 !== 0) begin
         n_fail++;
         $display("FAIL long_edge_counts: got short=%0d long=%0d expected 1/0", ns2, nl2);
      end
   endtask

   task automatic test_double_click();
      logic [5:0] e, o;
      int np, ns, nd, both;
      np = 0; ns = 0; nd = 0; both = 0;
      run(1'b1, 3);
      run(1'b0, 2);
      run(1'b1, 3);
      run(1'b0, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         np += int'(o[5]); ns += int'(o[3]); nd += int'(o[1]);
         if (o[1] && o[4]) both++;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL double_seq: got %b expected %b", o, e);
         end
      end
      n_cmp++;
      if (np !== 2 || ns !== 0 || nd !== 1 || both !== 1) begin
         n_fail++;
         $display("FAIL double_counts: got press=%0d short=%0d dbl=%0d coincident=%0d expected 2/0/1/1",
                  np, ns, nd, both);
      end
   endtask

   task automatic test_gap_boundary();
      logic [5:0] e, o;
      int ns, nd, ns2, nd2, np2;
      ns = 0; nd = 0; ns2 = 0; nd2 = 0; np2 = 0;
      run(1'b1, 3);
      run(1'b0, 6);
      run(1'b1, 3);
      run(1'b0, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         ns += int'(o[3]); nd += int'(o[1]);
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL gap6_seq: got %b expected %b", o, e);
         end
      end
      n_cmp++;
      if (ns !== 0 || nd !== 1) begin
         n_fail++;
         $display("FAIL gap6_counts: got short=%0d dbl=%0d expected 0/1", ns, nd);
      end
      run(1'b1, 3);
      run(1'b0, 7);
      run(1'b1, 3);
      run(1'b0, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         ns2 += int'(o[3]); nd2 += int'(o[1]); np2 += int'(o[5]);
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL gap7_seq: got %b expected %b", o, e);
         end
      end
      n_cmp++;
      if (ns2 !== 2 || nd2 !== 0 || np2 !== 2) begin
         n_fail++;
         $display("FAIL gap7_counts: got short=%0d dbl=%0d press=%0d expected 2/0/2", ns2, nd2, np2);
      end
   endtask

   task automatic test_reset_mid_hold();
      logic [5:0] e, o;
      int nl, nr;
      nl = 0; nr = 0;
      run(1'b1, 6);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL mid_hold_pre: got %b expected %b", o, e);
         end
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({press_pulse, release_pulse, short_press, long_press, double_click, held} !== 6'b0) begin
         n_fail++;
         $display("FAIL async_reset: got %b expected 000000",
                  {press_pulse, release_pulse, short_press, long_press, double_click, held});
      end
      model_clear();
      @(negedge clk);
      cycle(1'b0);
      cycle(1'b0);
      reset = 1'b1;
      run(1'b0, 15);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         nl += int'(o[2]); nr += int'(o[4]);
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL mid_hold_post: got %b expected %b", o, e);
         end
      end
      n_cmp++;
      if (nl !== 0 || nr !== 0) begin
         n_fail++;
         $display("FAIL mid_hold_counts: got long=%0d release=%0d expected 0/0", nl, nr);
      end
   endtask

   task automatic test_random();
      logic [5:0] e, o;
      for (int g = 0; g < 40; g++) begin
         run(1'b1, $urandom_range(1, 14));
         run(1'b0, $urandom_range(1, 9));
      end
      run(1'b0, 12);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL random_seq: got %b expected %b", o, e);
         end
      end
   endtask

   initial begin
      reset     = 1'b0;
      debounced = 1'b0;
      model_clear();
      test_reset();
      test_short_press();
      test_long_press();
      test_double_click();
      test_gap_boundary();
      test_reset_mid_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
